// File: rtl/adc_cfg_seq_if.sv
// Slow-control / serializer bundle for the ADC config sequencer.
// master: request side (INIT/SINGLE/SEL_ADR/ABORT); slave: sequencer.
interface adc_cfg_seq_if #(
  parameter int ADR_W = 5
);
  logic             INIT;
  logic             SINGLE;
  logic [ADR_W-1:0] SEL_ADR;
  logic             ABORT;
  logic [ADR_W-1:0] ADR;
  logic             LOAD;
  logic             SCKEN;
  logic             SHEN;
  logic             DONE;
  logic             BUSY;
  logic             ERR;

  modport master (
    output INIT,
    output SINGLE,
    output SEL_ADR,
    output ABORT,
    input  ADR,
    input  LOAD,
    input  SCKEN,
    input  SHEN,
    input  DONE,
    input  BUSY,
    input  ERR
  );

  modport slave (
    input  INIT,
    input  SINGLE,
    input  SEL_ADR,
    input  ABORT,
    output ADR,
    output LOAD,
    output SCKEN,
    output SHEN,
    output DONE,
    output BUSY,
    output ERR
  );
endinterface

// File: rtl/adc_cfg_seq.sv
// ADC config sequencer: walks FIRST_ADDR..LAST_ADDR (or one SEL_ADR),
// issuing LOAD then a SHIFT_LEN-cycle SCKEN/SHEN window per word.
// Ports: CLK, RST (sync, active-high), bus (adc_cfg_seq_if.slave):
//   in  INIT, SINGLE, SEL_ADR, ABORT
//   out ADR, LOAD, SCKEN, SHEN, DONE, BUSY, ERR
// Optional: define ADC_CFG_SEQ_TMR_EN for triplicated, voted state.
module adc_cfg_seq #(
  parameter int               ADR_W      = 5,
  parameter logic [ADR_W-1:0] FIRST_ADDR = '0,
  parameter logic [ADR_W-1:0] LAST_ADDR  = ADR_W'(16),
  parameter int               SHIFT_LEN  = 46,
  parameter int               GAP_CYC    = 0
) (
  input logic          CLK,
  input logic          RST,
  adc_cfg_seq_if.slave bus
);

  localparam int SW = $clog2(SHIFT_LEN + 1);
  localparam int GW =
    (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [SW-1:0] SH_LAST =
    SW'(SHIFT_LEN - 1);
  localparam logic [GW-1:0] GP_LAST =
    (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_GAP,
    S_INCR,
    S_LOAD,
    S_END,
    S_DONE
  } st_e;

  // Every piece of state lives in one packed word so the
  // redundant build can vote it with a single expression.
  typedef struct packed {
    st_e              st;
    logic [SW-1:0]    cnt;
    logic [GW-1:0]    gcnt;
    logic [ADR_W-1:0] adr;
    logic             single;
    logic             lock;
    logic             load;
    logic             scken;
    logic             shen;
    logic             done;
    logic             busy;
    logic             err;
  } reg_t;

  reg_t w_cur;
  reg_t w_nxt;
  logic w_in_rng;

  assign w_in_rng =
    (int'(bus.SEL_ADR) >= int'(FIRST_ADDR)) &&
    (int'(bus.SEL_ADR) <= int'(LAST_ADDR));

`ifdef ADC_CFG_SEQ_TMR_EN
  (* preserve, keep *) reg_t r_cp [3];

  always_comb begin
    w_cur = reg_t'((r_cp[0] & r_cp[1]) |
                   (r_cp[0] & r_cp[2]) |
                   (r_cp[1] & r_cp[2]));
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (RST) begin
        r_cp[i] <= '0;
      end else begin
        r_cp[i] <= w_nxt;
      end
    end
  end
`else
  reg_t r_q;

  always_comb begin
    w_cur = r_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= '0;
    end else begin
      r_q <= w_nxt;
    end
  end
`endif

  always_comb begin
    w_nxt     = w_cur;
    w_nxt.err = 1'b0;

    // busy is exactly the set of states where ABORT applies
    if (bus.ABORT && w_cur.busy) begin
      w_nxt.st  = S_IDLE;
      w_nxt.adr = '0;
    end else begin
      unique case (w_cur.st)
        S_IDLE: begin
          // lock holds off repeated ERR while SINGLE stays high
          w_nxt.lock = bus.SINGLE & w_cur.lock;
          if (bus.INIT) begin
            w_nxt.st     = S_START;
            w_nxt.adr    = FIRST_ADDR;
            w_nxt.single = 1'b0;
          end else if (bus.SINGLE && !w_cur.lock) begin
            if (w_in_rng) begin
              w_nxt.st     = S_START;
              w_nxt.adr    = bus.SEL_ADR;
              w_nxt.single = 1'b1;
            end else begin
              w_nxt.err  = 1'b1;
              w_nxt.lock = 1'b1;
            end
          end
        end
        S_START: begin
          w_nxt.st  = S_SHIFT;
          w_nxt.cnt = '0;
        end
        S_SHIFT: begin
          w_nxt.cnt = w_cur.cnt + SW'(1);
          if (w_cur.cnt == SH_LAST) begin
            if (w_cur.single ||
                w_cur.adr == LAST_ADDR) begin
              w_nxt.st = S_END;
            end else if (GAP_CYC > 0) begin
              w_nxt.st   = S_GAP;
              w_nxt.gcnt = '0;
            end else begin
              w_nxt.st = S_INCR;
            end
          end
        end
        S_GAP: begin
          w_nxt.gcnt = w_cur.gcnt + GW'(1);
          if (w_cur.gcnt == GP_LAST) begin
            w_nxt.st = S_INCR;
          end
        end
        S_INCR: begin
          w_nxt.st  = S_LOAD;
          w_nxt.adr = w_cur.adr + ADR_W'(1);
        end
        S_LOAD: begin
          w_nxt.st  = S_SHIFT;
          w_nxt.cnt = '0;
        end
        S_END: begin
          w_nxt.st  = S_DONE;
          w_nxt.adr = '0;
        end
        S_DONE: begin
          if (!bus.INIT && !bus.SINGLE) begin
            w_nxt.st = S_IDLE;
          end
        end
        default: begin
          w_nxt.st  = S_IDLE;
          w_nxt.adr = '0;
        end
      endcase
    end

    // outputs follow the state being entered
    w_nxt.load  = (w_nxt.st == S_START) ||
                  (w_nxt.st == S_LOAD);
    w_nxt.scken = (w_nxt.st == S_START) ||
                  (w_nxt.st == S_SHIFT) ||
                  (w_nxt.st == S_INCR)  ||
                  (w_nxt.st == S_LOAD)  ||
                  (w_nxt.st == S_END);
    w_nxt.shen  = (w_nxt.st == S_SHIFT) ||
                  (w_nxt.st == S_INCR)  ||
                  (w_nxt.st == S_LOAD);
    w_nxt.done  = (w_nxt.st == S_DONE);
    w_nxt.busy  = (w_nxt.st != S_IDLE) &&
                  (w_nxt.st != S_DONE);
  end

  assign bus.ADR   = w_cur.adr;
  assign bus.LOAD  = w_cur.load;
  assign bus.SCKEN = w_cur.scken;
  assign bus.SHEN  = w_cur.shen;
  assign bus.DONE  = w_cur.done;
  assign bus.BUSY  = w_cur.busy;
  assign bus.ERR   = w_cur.err;

endmodule

// File: tb/tb_adc_cfg_seq.sv
// Directed bench for adc_cfg_seq: default build (a) and GAP_CYC=3 (b).
// Inputs driven and outputs sampled on the falling edge.
module tb_adc_cfg_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  adc_cfg_seq_if #(.ADR_W(5)) bus_a ();
  adc_cfg_seq_if #(.ADR_W(5)) bus_b ();

  adc_cfg_seq #(
    .ADR_W(5), .FIRST_ADDR(5'h00), .LAST_ADDR(5'h10),
    .SHIFT_LEN(46), .GAP_CYC(0)
  ) dut_a (
    .CLK(clk), .RST(rst), .bus(bus_a.slave)
  );

  adc_cfg_seq #(
    .ADR_W(5), .FIRST_ADDR(5'h00), .LAST_ADDR(5'h10),
    .SHIFT_LEN(46), .GAP_CYC(3)
  ) dut_b (
    .CLK(clk), .RST(rst), .bus(bus_b.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  function automatic int outs_a();
    return {26'd0, bus_a.LOAD, bus_a.SCKEN, bus_a.SHEN,
            bus_a.DONE, bus_a.BUSY, bus_a.ERR};
  endfunction

  function automatic int outs_b();
    return {26'd0, bus_b.LOAD, bus_b.SCKEN, bus_b.SHEN,
            bus_b.DONE, bus_b.BUSY, bus_b.ERR};
  endfunction

  int t0, td, nl, ns, nh, bad, ea, run, mrun;
  int ng, nw, gbad, ne, nerr, nbusy, k, la;
  logic pg;

  initial begin
    rst = 1'b1;
    bus_a.INIT = 0; bus_a.SINGLE = 0;
    bus_a.SEL_ADR = '0; bus_a.ABORT = 0;
    bus_b.INIT = 0; bus_b.SINGLE = 0;
    bus_b.SEL_ADR = '0; bus_b.ABORT = 0;
    repeat (3) @(negedge clk);
    chk("rst_outs_a", outs_a(), 0);
    chk("rst_adr_a", int'(bus_a.ADR), 0);
    chk("rst_outs_b", outs_b(), 0);
    rst = 1'b0;
    @(negedge clk);

    // ---- full sequence, no gap ----
    bus_a.INIT = 1;
    t0 = -1; td = -1; nl = 0; ns = 0; nh = 0;
    bad = 0; ea = 0; run = 0; mrun = 0;
    for (int c = 0; c < 2000 && td < 0; c++) begin
      @(negedge clk);
      if (bus_a.LOAD) begin
        if (t0 < 0) t0 = c;
        if (int'(bus_a.ADR) != ea) bad++;
        ea++; nl++;
      end
      if (bus_a.SCKEN) begin
        ns++; run++;
        if (run > mrun) mrun = run;
      end else run = 0;
      if (bus_a.SHEN) nh++;
      if (bus_a.DONE) td = c;
    end
    chk("full_done_seen", int'(td >= 0), 1);
    chk("full_load_cnt", nl, 17);
    chk("full_adr_seq", bad, 0);
    chk("full_scken_cnt", ns, 816);
    chk("full_scken_run", mrun, 816);
    chk("full_shen_cnt", nh, 814);
    chk("full_done_lat", td - t0, 816);
    repeat (3) @(negedge clk);
    chk("full_done_hold", int'(bus_a.DONE), 1);
    chk("full_done_adr", int'(bus_a.ADR), 0);
    chk("full_done_busy", int'(bus_a.BUSY), 0);
    bus_a.INIT = 0;
    @(negedge clk);
    chk("full_idle_outs", outs_a(), 0);

    // ---- full sequence with 3-cycle gaps ----
    bus_b.INIT = 1;
    t0 = -1; td = -1; nl = 0; ns = 0;
    ng = 0; nw = 0; gbad = 0; pg = 1'b0;
    for (int c = 0; c < 3000 && td < 0; c++) begin
      @(negedge clk);
      if (bus_b.LOAD) begin
        if (t0 < 0) t0 = c;
        nl++;
      end
      if (bus_b.SCKEN) ns++;
      if (bus_b.BUSY && !bus_b.SCKEN) begin
        ng++;
        if (!pg) nw++;
        if (bus_b.LOAD || bus_b.SHEN) gbad++;
        pg = 1'b1;
      end else pg = 1'b0;
      if (bus_b.DONE) td = c;
    end
    chk("gap_done_seen", int'(td >= 0), 1);
    chk("gap_load_cnt", nl, 17);
    chk("gap_windows", nw, 16);
    chk("gap_cycles", ng, 48);
    chk("gap_quiet", gbad, 0);
    chk("gap_scken_cnt", ns, 816);
    chk("gap_done_lat", td - t0, 864);
    bus_b.INIT = 0;
    @(negedge clk);
    chk("gap_idle_outs", outs_b(), 0);

    // ---- single rewrite at address 5 ----
    bus_a.SEL_ADR = 5'd5;
    bus_a.SINGLE  = 1;
    td = -1; nl = 0; nh = 0; ne = 0; la = -1;
    for (int c = 0; c < 200 && td < 0; c++) begin
      @(negedge clk);
      if (bus_a.LOAD) begin
        nl++; la = int'(bus_a.ADR);
      end
      if (bus_a.SHEN) nh++;
      if (bus_a.SCKEN && !bus_a.SHEN && !bus_a.LOAD)
        ne++;
      if (bus_a.DONE) td = c;
    end
    chk("single_done", int'(td >= 0), 1);
    chk("single_loads", nl, 1);
    chk("single_adr", la, 5);
    chk("single_shen", nh, 46);
    chk("single_end", ne, 1);
    bus_a.SINGLE = 0;
    @(negedge clk);
    chk("single_idle", outs_a(), 0);

    // ---- single out of range ----
    bus_a.SEL_ADR = 5'd20;
    bus_a.SINGLE  = 1;
    nerr = 0; nbusy = 0;
    @(negedge clk);
    chk("err_first", int'(bus_a.ERR), 1);
    nerr++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus_a.ERR) nerr++;
      if (bus_a.BUSY) nbusy++;
    end
    chk("err_pulses", nerr, 1);
    chk("err_busy", nbusy, 0);
    bus_a.SINGLE = 0;
    @(negedge clk);

    // ---- INIT wins over SINGLE ----
    bus_a.SEL_ADR = 5'd7;
    bus_a.SINGLE  = 1;
    bus_a.INIT    = 1;
    @(negedge clk);
    chk("both_load", int'(bus_a.LOAD), 1);
    chk("both_adr", int'(bus_a.ADR), 0);
    bus_a.SINGLE = 0;

    // ---- abort at shift cycle 10 of word 3 ----
    k = 0;
    for (int c = 0; c < 400 && k < 10; c++) begin
      @(negedge clk);
      if (bus_a.ADR == 5'd3 && bus_a.SHEN &&
          !bus_a.LOAD) k++;
    end
    chk("abort_reach", k, 10);
    bus_a.ABORT = 1;
    bus_a.INIT  = 0;
    @(negedge clk);
    bus_a.ABORT = 0;
    chk("abort_outs", outs_a(), 0);
    chk("abort_adr", int'(bus_a.ADR), 0);
    nbusy = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (outs_a() != 0) nbusy++;
    end
    chk("abort_quiet", nbusy, 0);
    bus_a.INIT = 1;
    @(negedge clk);
    chk("restart_load", int'(bus_a.LOAD), 1);
    chk("restart_adr", int'(bus_a.ADR), 0);
    repeat (20) @(negedge clk);
    chk("mid_shift_shen", int'(bus_a.SHEN), 1);

`ifdef ADC_CFG_SEQ_TMR_EN
    dut_a.r_cp[1].st = dut_a.S_DONE;
    #1;
    chk("tmr_port_shen", int'(bus_a.SHEN), 1);
    chk("tmr_port_done", int'(bus_a.DONE), 0);
    @(negedge clk);
    chk("tmr_realign",
        int'(dut_a.r_cp[1].st == dut_a.r_cp[0].st), 1);
    chk("tmr_port_busy", int'(bus_a.BUSY), 1);
`endif

    // ---- reset mid-shift ----
    rst = 1'b1;
    bus_a.INIT = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_outs", outs_a(), 0);
    chk("rst_mid_adr", int'(bus_a.ADR), 0);
    repeat (3) @(negedge clk);
    chk("rst_mid_idle", outs_a(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
